// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the robot command frame receiver.
package rx_frame_ctrl_pkg;

    // State encoding is fixed so it can be read directly off a probe.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ID      = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } rx_state_e;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN   = 7;
    // HDR, ID and CHK surround the payload slots.
    localparam int         PAYLOAD_LEN = FRAME_LEN - 3;
    localparam int         GAP_W       = 16;

    // One decoded motion command, in frame byte order.
    typedef struct packed {
        logic [7:0] vel_x;
        logic [7:0] vel_y;
        logic [7:0] vel_w;
        logic [7:0] kick;
    } cmd_t;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Byte stream in from the UART receiver, decoded command and status out.
interface rx_frame_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] vel_x;
    logic [7:0] vel_y;
    logic [7:0] vel_w;
    logic [7:0] kick;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    // Byte source side (UART receiver / command consumer).
    modport master (
        output rx_byte, rx_valid,
        input  vel_x, vel_y, vel_w, kick, frame_valid, frame_err, busy
    );

    // Frame controller side.
    modport slave (
        input  rx_byte, rx_valid,
        output vel_x, vel_y, vel_w, kick, frame_valid, frame_err, busy
    );
endinterface

// File: rtl/rx_frame_ctrl_gap.sv
// Inter-byte gap timer: counts idle cycles and pulses expire on the last allowed one.
module rx_gap_timer #(
    parameter int TIMEOUT = 20000,
    parameter int W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // A clear in the expiry cycle (new byte) suppresses the timeout.
    assign expire = en && !clr && (cnt_q == LAST);

    // Gap counter: restarts on clear or expiry, otherwise counts while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr || expire)
            cnt_q <= '0;
        else if (en)
            cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/rx_frame_ctrl.sv
// Robot command frame decoder: HDR, ID, 4 payload bytes, XOR checksum.
module rx_frame_ctrl #(
    parameter logic [3:0] MY_ID   = 4'h3,
    parameter int         TIMEOUT = 20000,
    parameter logic [7:0] HDR     = rx_frame_ctrl_pkg::HDR_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    rx_frame_ctrl_if.slave bus
);
    import rx_frame_ctrl_pkg::*;

    rx_state_e                     state, state_nxt;
    logic [7:0]                    id_q;
    logic [7:0]                    xsum_q;
    logic [PAYLOAD_LEN-1:0][7:0]   slot_q;
    logic [1:0]                    idx_q;
    cmd_t                          cmd_q;
    logic                          fv_q, fe_q;
    logic                          in_idle, expire, accept, chk_bad;

    assign in_idle = (state == IDLE);

    rx_gap_timer #(.TIMEOUT(TIMEOUT), .W(GAP_W)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (bus.rx_valid || in_idle),
        .en     (!in_idle),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus accept/checksum-fail decisions on the CHK byte.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        chk_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_byte == HDR)
                    state_nxt = ID;
            end
            ID: begin
                if (bus.rx_valid)
                    state_nxt = PAYLOAD;
                else if (expire)
                    state_nxt = IDLE;
            end
            PAYLOAD: begin
                if (bus.rx_valid && idx_q == 2'd3)
                    state_nxt = CHECK;
                else if (expire)
                    state_nxt = IDLE;
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    state_nxt = IDLE;
                    // A foreign ID with a good checksum is silently dropped.
                    if (bus.rx_byte == xsum_q)
                        accept = (id_q[3:0] == MY_ID);
                    else
                        chk_bad = 1'b1;
                end else if (expire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame datapath: ID, shadow slots, running XOR, latched command and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= '0;
            xsum_q <= '0;
            slot_q <= '0;
            idx_q  <= '0;
            cmd_q  <= '0;
            fv_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            fv_q <= accept;
            fe_q <= chk_bad || expire;
            if (accept)
                cmd_q <= '{vel_x: slot_q[0], vel_y: slot_q[1],
                           vel_w: slot_q[2], kick:  slot_q[3]};
            if (expire) begin
                id_q   <= '0;
                xsum_q <= '0;
                slot_q <= '0;
                idx_q  <= '0;
            end else if (bus.rx_valid) begin
                case (state)
                    IDLE: begin
                        idx_q  <= '0;
                        xsum_q <= '0;
                    end
                    ID: begin
                        id_q   <= bus.rx_byte;
                        xsum_q <= bus.rx_byte;
                    end
                    PAYLOAD: begin
                        // Index wraps back to 0 after slot 3.
                        slot_q[idx_q] <= bus.rx_byte;
                        xsum_q        <= xsum_q ^ bus.rx_byte;
                        idx_q         <= idx_q + 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.vel_x       = cmd_q.vel_x;
    assign bus.vel_y       = cmd_q.vel_y;
    assign bus.vel_w       = cmd_q.vel_w;
    assign bus.kick        = cmd_q.kick;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.busy        = !in_idle;
endmodule
